// File: rtl/dice_roller_if.sv
// Button level in, per-die faces, LED pips, sum and roll status out.
// master = button/display side, slave = dice_roller.
interface dice_roller_if #(
  parameter int N_DICE = 2
);
  logic                  i_Switch;
  logic [3*N_DICE-1:0]   o_Values;
  logic [7*N_DICE-1:0]   o_Pips;
  logic [6:0]            o_Sum;
  logic                  o_Busy;
  logic                  o_Done;

  modport master (output i_Switch, input o_Values, o_Pips, o_Sum, o_Busy, o_Done);
  modport slave  (input i_Switch, output o_Values, o_Pips, o_Sum, o_Busy, o_Done);
endinterface

// File: rtl/dice_roller.sv
// Multi-die roller: free-running LFSR-stepped face counters, animated roll on button release.
// Final faces land TICK_CYCLES*ROLL_STEPS clocks after the release; releases while busy are dropped.
module dice_roller #(
  parameter int          N_DICE      = 2,
  parameter int          N_SIDES     = 6,
  parameter int          TICK_CYCLES = 4,
  parameter int          ROLL_STEPS  = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  dice_roller_if.slave  io_Bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] ROLLING = 1'b1;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(ROLL_STEPS - 1);
  localparam logic [2:0]    FACE_MAX  = 3'(N_SIDES);

  function automatic logic [6:0] f_Pips(input logic [2:0] v);
    case (v)
      3'd1:    f_Pips = 7'b0001000;
      3'd2:    f_Pips = 7'b1000001;
      3'd3:    f_Pips = 7'b1001001;
      3'd4:    f_Pips = 7'b1100011;
      3'd5:    f_Pips = 7'b1101011;
      3'd6:    f_Pips = 7'b1110111;
      default: f_Pips = 7'b0000000;
    endcase
  endfunction

  logic [15:0]         r_Lfsr;
  logic [3*N_DICE-1:0] r_Die;
  logic                r_Switch;
  logic [0:0]          r_State;
  logic [TW-1:0]       r_Tick;
  logic [SW-1:0]       r_Step;
  logic [3*N_DICE-1:0] r_Values;
  logic [7*N_DICE-1:0] r_Pips;
  logic [6:0]          r_Sum;
  logic                r_Busy;
  logic                r_Done;

  logic                w_Fb;
  logic                w_Release;
  logic [3*N_DICE-1:0] w_DieNext;
  logic [7*N_DICE-1:0] w_PipsNow;
  logic [6:0]          w_Sum;

  assign w_Fb      = r_Lfsr[15] ^ r_Lfsr[13] ^ r_Lfsr[12] ^ r_Lfsr[10];
  assign w_Release = ~io_Bus.i_Switch & r_Switch;

  // Die k steps whenever LFSR bit k is set, so the dice decorrelate from each other.
  always_comb begin
    w_DieNext = r_Die;
    w_PipsNow = '0;
    w_Sum     = '0;
    for (int k = 0; k < N_DICE; k++) begin
      if (r_Lfsr[k]) begin
        w_DieNext[3*k +: 3] = (r_Die[3*k +: 3] == FACE_MAX) ? 3'd1 : r_Die[3*k +: 3] + 3'd1;
      end
      w_PipsNow[7*k +: 7] = f_Pips(r_Die[3*k +: 3]);
      w_Sum = w_Sum + 7'(r_Die[3*k +: 3]);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Lfsr   <= LFSR_SEED;
      r_Die    <= {N_DICE{3'd1}};
      r_Switch <= 1'b0;
      r_State  <= IDLE;
      r_Tick   <= '0;
      r_Step   <= '0;
      r_Values <= {N_DICE{3'd1}};
      r_Pips   <= {N_DICE{7'b0001000}};
      r_Sum    <= 7'(N_DICE);
      r_Busy   <= 1'b0;
      r_Done   <= 1'b0;
    end else begin
      r_Lfsr   <= {r_Lfsr[14:0], w_Fb};
      r_Die    <= w_DieNext;
      r_Switch <= io_Bus.i_Switch;
      r_Done   <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_Release) begin
            r_State <= ROLLING;
            r_Tick  <= '0;
            r_Step  <= '0;
            r_Busy  <= 1'b1;
          end
        end
        ROLLING: begin
          if (r_Tick == TICK_LAST) begin
            r_Tick   <= '0;
            r_Values <= r_Die;
            r_Pips   <= w_PipsNow;
            if (r_Step == STEP_LAST) begin
              r_Sum   <= w_Sum;
              r_Done  <= 1'b1;
              r_Busy  <= 1'b0;
              r_Step  <= '0;
              r_State <= IDLE;
            end else begin
              r_Step <= r_Step + SW'(1);
            end
          end else begin
            r_Tick <= r_Tick + TW'(1);
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign io_Bus.o_Values = r_Values;
  assign io_Bus.o_Pips   = r_Pips;
  assign io_Bus.o_Sum    = r_Sum;
  assign io_Bus.o_Busy   = r_Busy;
  assign io_Bus.o_Done   = r_Done;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: two configurations checked every cycle against a roll-level model,
// plus a cycle table for roll timing and directed corner sequences.
module tb_dice_roller;
  localparam int T = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dice_roller_if #(.N_DICE(2)) bus0 ();
  dice_roller_if #(.N_DICE(4)) bus2 ();

  dice_roller #(.N_DICE(2), .N_SIDES(6), .TICK_CYCLES(T), .ROLL_STEPS(S), .LFSR_SEED(16'hACE1))
    dut (.i_Clk(clk), .i_Rst(rst), .io_Bus(bus0));
  dice_roller #(.N_DICE(4), .N_SIDES(2), .TICK_CYCLES(T), .ROLL_STEPS(S), .LFSR_SEED(16'hACE1))
    dut2 (.i_Clk(clk), .i_Rst(rst), .io_Bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pipf(input int v);
    case (v)
      1: pipf = 7'b0001000;
      2: pipf = 7'b1000001;
      3: pipf = 7'b1001001;
      4: pipf = 7'b1100011;
      5: pipf = 7'b1101011;
      6: pipf = 7'b1110111;
      default: pipf = 7'b0000000;
    endcase
  endfunction

  // Actual outputs, zero-extended so both configurations share one checker.
  logic [47:0]  a_val  [2];
  logic [111:0] a_pip  [2];
  logic [6:0]   a_sum  [2];
  logic         a_busy [2];
  logic         a_done [2];
  always_comb begin
    a_val[0] = 48'(bus0.o_Values);  a_val[1] = 48'(bus2.o_Values);
    a_pip[0] = 112'(bus0.o_Pips);   a_pip[1] = 112'(bus2.o_Pips);
    a_sum[0] = bus0.o_Sum;          a_sum[1] = bus2.o_Sum;
    a_busy[0] = bus0.o_Busy;        a_busy[1] = bus2.o_Busy;
    a_done[0] = bus0.o_Done;        a_done[1] = bus2.o_Done;
  end

  // Reference model: a roll started at cycle c shows the counters' values at c+T, c+2T, ... c+S*T.
  int nd  [2] = '{2, 4};
  int nsd [2] = '{6, 2};
  int m_lfsr [2];
  int m_die  [2][16];
  int m_old  [16];
  int e_val  [2][16];
  int e_sum  [2];
  bit e_busy [2];
  bit e_done [2];
  bit m_prev [2];
  bit m_roll [2];
  int m_start [2];
  int m_cyc = 0;
  int m_el;
  bit m_sw;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      m_sw = (i == 0) ? bus0.i_Switch : bus2.i_Switch;
      if (rst) begin
        m_lfsr[i] = 16'hACE1;
        for (int k = 0; k < 16; k++) begin
          m_die[i][k] = 1;
          e_val[i][k] = 1;
        end
        e_sum[i] = nd[i];
        e_busy[i] = 0;
        e_done[i] = 0;
        m_prev[i] = 0;
        m_roll[i] = 0;
      end else begin
        e_done[i] = 0;
        for (int k = 0; k < 16; k++) m_old[k] = m_die[i][k];
        if (m_roll[i]) begin
          m_el = m_cyc - m_start[i];
          if (m_el % T == 0) begin
            for (int k = 0; k < 16; k++) e_val[i][k] = m_old[k];
            if (m_el == T * S) begin
              e_sum[i] = 0;
              for (int k = 0; k < nd[i]; k++) e_sum[i] += m_old[k];
              e_done[i] = 1;
              e_busy[i] = 0;
              m_roll[i] = 0;
            end
          end
        end else if (!m_sw && m_prev[i]) begin
          m_roll[i] = 1;
          m_start[i] = m_cyc;
          e_busy[i] = 1;
        end
        for (int k = 0; k < nd[i]; k++)
          if (((m_lfsr[i] >> k) & 1) == 1) m_die[i][k] = m_die[i][k] % nsd[i] + 1;
        m_lfsr[i] = ((m_lfsr[i] << 1) & 16'hFFFF) | ($countones(m_lfsr[i] & 16'hB400) & 1);
        m_prev[i] = m_sw;
      end
    end
  end

  logic [47:0]  ev;
  logic [111:0] ep;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        ev = '0;
        ep = '0;
        for (int k = 0; k < nd[i]; k++) begin
          ev[3*k +: 3] = 3'(e_val[i][k]);
          ep[7*k +: 7] = pipf(e_val[i][k]);
        end
        check(i == 0 ? "model_values0" : "model_values1", 128'(a_val[i]), 128'(ev));
        check(i == 0 ? "model_pips0"   : "model_pips1",   128'(a_pip[i]), 128'(ep));
        check(i == 0 ? "model_sum0"    : "model_sum1",    128'(a_sum[i]), 128'(e_sum[i]));
        check(i == 0 ? "model_busy0"   : "model_busy1",   128'(a_busy[i]), 128'(e_busy[i]));
        check(i == 0 ? "model_done0"   : "model_done1",   128'(a_done[i]), 128'(e_done[i]));
      end
    end
  end

  task automatic set_sw(input int i, input logic v);
    if (i == 0) bus0.i_Switch = v;
    else        bus2.i_Switch = v;
  endtask

  // Idle for gap cycles, press for hold cycles, release, then wait (bounded) for o_Done.
  task automatic roll(input int i, input int gap, input int hold);
    bit seen;
    seen = 0;
    set_sw(i, 1'b0);
    repeat (gap) @(negedge clk);
    set_sw(i, 1'b1);
    repeat (hold) @(negedge clk);
    set_sw(i, 1'b0);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (a_done[i]) seen = 1;
    end
    check("roll_done_seen", 128'(seen), 128'(1));
  endtask

  typedef struct {
    bit sw;
    bit busy;
    bit done;
    bit chg;
  } vec_t;
  vec_t vt [17];

  initial begin
    logic [47:0] prev;
    int dcnt, fsum;
    bit ok;

    vt[0]  = '{1, 0, 0, 0};  vt[1]  = '{1, 0, 0, 0};  vt[2]  = '{1, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 0};  vt[4]  = '{0, 1, 0, 0};  vt[5]  = '{0, 1, 0, 0};
    vt[6]  = '{0, 1, 0, 0};  vt[7]  = '{0, 1, 0, 1};  vt[8]  = '{0, 1, 0, 0};
    vt[9]  = '{0, 1, 0, 0};  vt[10] = '{0, 1, 0, 0};  vt[11] = '{0, 1, 0, 1};
    vt[12] = '{0, 1, 0, 0};  vt[13] = '{0, 1, 0, 0};  vt[14] = '{0, 1, 0, 0};
    vt[15] = '{0, 0, 1, 1};  vt[16] = '{0, 0, 0, 0};

    bus0.i_Switch = 1'b0;
    bus2.i_Switch = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;

    // Reset, then 5 idle cycles.
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t1_values", 128'(a_val[0]), 128'h9);
    check("t1_pips",   128'(a_pip[0]), 128'h408);
    check("t1_sum",    128'(a_sum[0]), 128'd2);
    check("t1_busy",   128'(a_busy[0]), 128'd0);
    check("t1_done",   128'(a_done[0]), 128'd0);
    check("t1_sum4",   128'(a_sum[1]), 128'd4);
    check("t1_values4", 128'(a_val[1]), 128'h249);

    // Cycle table: release at edge 3, updates at 7, 11, 15.
    prev = a_val[0];
    for (int j = 0; j < 17; j++) begin
      bus0.i_Switch = vt[j].sw;
      @(negedge clk);
      check("t2_busy", 128'(a_busy[0]), 128'(vt[j].busy));
      check("t2_done", 128'(a_done[0]), 128'(vt[j].done));
      if (!vt[j].chg) check("t2_values_hold", 128'(a_val[0]), 128'(prev));
      prev = a_val[0];
    end
    fsum = 0;
    ok = 1;
    for (int k = 0; k < 2; k++) begin
      if (a_val[0][3*k +: 3] < 3'd1 || a_val[0][3*k +: 3] > 3'd6) ok = 0;
      fsum += int'(a_val[0][3*k +: 3]);
    end
    check("t2_face_range", 128'(ok), 128'(1));
    check("t2_sum", 128'(a_sum[0]), 128'(fsum));

    // Twenty rolls with random gaps; the model checks every snapshot and sum.
    for (int r = 0; r < 20; r++) roll(0, $urandom_range(0, 9), $urandom_range(1, 4));

    // Releases during a roll are ignored.
    bus0.i_Switch = 1'b1;
    repeat (2) @(negedge clk);
    bus0.i_Switch = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 1 || c == 3) bus0.i_Switch = 1'b1;
      if (c == 2 || c == 4) bus0.i_Switch = 1'b0;
      if (a_done[0]) dcnt++;
    end
    check("t4_one_done", 128'(dcnt), 128'd1);
    check("t4_idle", 128'(a_busy[0]), 128'd0);

    // Reset at E+6 aborts the roll.
    bus0.i_Switch = 1'b1;
    repeat (2) @(negedge clk);
    bus0.i_Switch = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_busy_before", 128'(a_busy[0]), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy",   128'(a_busy[0]), 128'd0);
    check("t5_values", 128'(a_val[0]), 128'h9);
    check("t5_pips",   128'(a_pip[0]), 128'h408);
    check("t5_sum",    128'(a_sum[0]), 128'd2);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_done[0]) dcnt++;
    end
    check("t5_no_done", 128'(dcnt), 128'd0);
    roll(0, 3, 2);

    // Two-sided, four-die configuration.
    for (int r = 0; r < 50; r++) begin
      roll(1, $urandom_range(0, 7), $urandom_range(1, 3));
      ok = 1;
      for (int k = 0; k < 4; k++) begin
        if (a_val[1][3*k +: 3] != 3'd1 && a_val[1][3*k +: 3] != 3'd2) ok = 0;
        if (a_pip[1][7*k +: 7] != 7'b0001000 && a_pip[1][7*k +: 7] != 7'b1000001) ok = 0;
      end
      if (a_sum[1] < 7'd4 || a_sum[1] > 7'd8) ok = 0;
      check("t6_range", 128'(ok), 128'(1));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Multi-die roller: the successor to the single-die FPGA dice block.
- Rolls N_DICE independent dice with N_SIDES faces each, driven by a shared 16-bit LFSR.
- A release of the debounced button starts an animated roll of ROLL_STEPS display updates, one every TICK_CYCLES clocks. The final faces are then latched, and a sum plus a done pulse are produced.
- Sits between the debounce block and the PMOD LED drivers. Per-die pip patterns go directly to the LEDs.

Parameters:
- N_DICE, 2, number of dice; legal range 1..16.
- N_SIDES, 6, faces per die; legal range 2..6.
- TICK_CYCLES, 4, clocks between animation updates; must be >=1.
- ROLL_STEPS, 3, number of animation updates per roll, including the final one; must be >=1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_Switch  in  1  debounced button level; 1 = pressed.
- o_Values  out  3*N_DICE  displayed face of each die, binary 1..N_SIDES; die k occupies bits [3k+2:3k].
- o_Pips  out  7*N_DICE  LED pattern of each die; die k occupies bits [7k+6:7k].
- o_Sum  out  7  sum of the final faces of the last completed roll.
- o_Busy  out  1  high while a roll is in progress.
- o_Done  out  1  one-cycle pulse when the final faces are presented.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset i_Rst is synchronous and active-high. All state is updated only on rising edges of i_Clk.
- Reset values:
  - LFSR = LFSR_SEED.
  - All die counters = 1.
  - o_Values: every die = 1.
  - o_Pips: every die = 1-pattern.
  - o_Sum = N_DICE.
  - o_Busy = 0, o_Done = 0.
  - State = IDLE; step and tick counters = 0.
  - Edge register = 0.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left every cycle when not in reset.
  - The new bit 0 is the XOR of bits 15, 13, 12 and 10.
- Die counters: counter k advances every cycle in which lfsr[k]==1. Advance is +1, wrapping from N_SIDES to 1. Counters run in every state.
- Edge detect:
  - r_Switch <= i_Switch every cycle.
  - A release is i_Switch==0 && r_Switch==1, evaluated at the clock edge.
- FSM, IDLE state:
  - On a release: go to ROLLING at that edge; tick counter = 0, step counter = 0, o_Busy <= 1.
  - Otherwise hold.
- FSM, ROLLING state:
  - The tick counter counts 0..TICK_CYCLES-1.
  - At the edge where it equals TICK_CYCLES-1:
    - o_Values <= snapshot of the die counters.
    - o_Pips <= the matching patterns.
    - The step counter increments and the tick counter returns to 0.
  - On the tick that completes step ROLL_STEPS:
    - o_Sum <= sum of the snapshot.
    - o_Done <= 1 for exactly one cycle.
    - o_Busy <= 0.
    - Return to IDLE.
- Latency: if the release is detected at edge E, the first update is at edge E+TICK_CYCLES. The final update, o_Done, and the o_Busy fall all occur at edge E+TICK_CYCLES*ROLL_STEPS.
- Releases while ROLLING are ignored; they are not queued. A release on the same edge that returns to IDLE is also ignored.
- Pip bit order within each die's 7-bit field:
  - [6] top-left, [5] top-right, [4] mid-left, [3] centre, [2] mid-right, [1] bottom-left, [0] bottom-right.
- Pip patterns:
  - 1 = 0001000
  - 2 = 1000001
  - 3 = 1001001
  - 4 = 1100011
  - 5 = 1101011
  - 6 = 1110111
- o_Sum is zero-extended to 7 bits; the maximum value is 16*6 = 96, so it cannot overflow.
- Reset mid-roll: aborts the roll on that edge. All reset values apply and no o_Done is generated.

Test Plan:
1. Reset then hold 5 cycles -> o_Values = all 1s, o_Pips per die = 0001000, o_Sum = 2, o_Busy = 0, o_Done = 0.
2. Defaults; i_Switch 1 for 3 cycles then 0; release at edge E -> o_Busy = 1 from E. o_Values change only at E+4, E+8 and E+12. o_Done high only in the cycle after E+12; o_Sum equals the sum of both faces; each face is in 1..6; o_Busy = 0 after E+12.
3. Golden model: mirror the LFSR and counters from LFSR_SEED; perform 20 rolls with random gaps -> every o_Values snapshot and o_Sum match the model bit-exactly.
4. Toggle i_Switch 1->0 twice during ROLLING -> exactly one o_Done pulse; no second roll starts.
5. Assert i_Rst at E+6 -> reset values at the next edge; no o_Done; a subsequent release rolls normally.
6. N_SIDES=2, N_DICE=4, 50 rolls -> all faces in {1,2}, pips only 0001000 or 1000001, o_Sum in 4..8.
